recovery_sequencer: RTL
=======================

RECOVERY_SEQUENCER -- requirements
Module: recovery_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width.
REQ-002 SHALL have parameter ROB_TAG_W, default 5: ROB tag width.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15: maximum number of WAIT_ACK cycles.
REQ-004 SHALL have parameter RESTORE_CYCLES, default 2: length of the rename-map restore, minimum 1.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 mispredict_valid  in  1  branch mispredict reported this cycle.
REQ-008 mispredict_pc  in  XLEN  correct target PC.
REQ-009 mispredict_tag  in  ROB_TAG_W  ROB tag of the mispredicted branch.
REQ-010 rob_head_tag  in  ROB_TAG_W  current ROB head, used for age comparison.
REQ-011 rs_flush_ack, rob_flush_ack, lsq_flush_ack  in  1 each  single-cycle flush-done pulses.
REQ-012 redirect_ready  in  1  fetch accepts the redirect.
REQ-013 flush_req  out  1  one-cycle flush command to RS, ROB and LSQ.
REQ-014 flush_tag  out  ROB_TAG_W  flush boundary; entries younger than this tag are killed.
REQ-015 restore_map  out  1  rename-map checkpoint restore enable.
REQ-016 redirect_valid  out  1, redirect_pc  out  XLEN  fetch redirect.
REQ-017 stall_front  out  1  holds fetch, decode and dispatch.
REQ-018 timeout_err  out  1  sticky ack-timeout flag.
REQ-019 state  out  3  encoding IDLE=0, FLUSH=1, WAIT_ACK=2, RESTORE=3, REDIRECT=4.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 IDLE: when mispredict_valid is high, the block SHALL capture pc and tag into cur_pc/cur_tag and go to FLUSH; flush_req is therefore high one cycle after the mispredict.
REQ-022 FLUSH: flush_req SHALL be 1 for exactly one cycle with flush_tag=cur_tag; the next state SHALL be WAIT_ACK.
REQ-023 Ack pulses SHALL be collected into three sticky bits from the FLUSH cycle onward; all three bits SHALL be cleared on entry to FLUSH.
REQ-024 WAIT_ACK: when all three bits are set (counting acks arriving this cycle), the next state SHALL be RESTORE.
REQ-025 WAIT_ACK SHALL count cycles spent in the state; if the count reaches ACK_TIMEOUT before all acks arrive, the block SHALL set timeout_err and go to RESTORE.
REQ-026 timeout_err SHALL be cleared only by rst.
REQ-027 RESTORE: restore_map SHALL be 1 for exactly RESTORE_CYCLES consecutive cycles, then the next state SHALL be REDIRECT.
REQ-028 REDIRECT: redirect_valid SHALL be 1 with redirect_pc=cur_pc, both held stable until redirect_ready; on valid&&ready the next state SHALL be IDLE.
REQ-029 stall_front SHALL be 1 whenever state != IDLE.
REQ-030 Age of a tag SHALL be (tag - rob_head_tag) mod 2^ROB_TAG_W; smaller age means older.
REQ-031 A mispredict arriving in any non-IDLE state with age < age(cur_tag) SHALL recapture pc and tag, clear ack bits and counters, and go to FLUSH.
REQ-032 A non-IDLE mispredict with age >= age(cur_tag) SHALL be ignored.
REQ-033 In REDIRECT, an older mispredict SHALL take priority over redirect_ready: the next state is FLUSH and redirect_valid drops.
REQ-034 In the cycle the state leaves IDLE, mispredict_valid SHALL be evaluated as in IDLE.

Reset
REQ-035 On rst, state SHALL be IDLE and every output, cur_pc, cur_tag, ack bits, counters and timeout_err SHALL be 0 on the next edge.
REQ-036 rst SHALL take effect in any state, including mid-REDIRECT.
REQ-037 A mispredict in the same cycle as rst SHALL be dropped.

Verification (ACK_TIMEOUT=15, RESTORE_CYCLES=2, ROB_TAG_W=5)
REQ-038 Mispredict cyc0 pc=0x100 tag=3, all acks cyc3, ready cyc6 -> flush_req cyc1 only, restore_map cyc4-5, redirect_valid pc=0x100 cyc6, IDLE/stall_front=0 cyc7.
REQ-039 rs/rob ack given, lsq ack never -> after 15 WAIT_ACK cycles timeout_err=1, RESTORE entered, normal redirect follows.
REQ-040 head=0, cur_tag=10 in WAIT_ACK, mispredict tag=4 -> flush_req re-pulses with flush_tag=4, acks re-collected from zero.
REQ-041 head=0, cur_tag=10, mispredict tag=12 -> ignored; sequence completes with redirect to original pc.
REQ-042 Wrap: head=30, cur_tag=2 (age 4), mispredict tag=31 (age 1) -> restart with flush_tag=31.
REQ-043 rst during REDIRECT with redirect_ready=0 -> next cycle state=0, all outputs 0.

Source files
------------

// File: rtl/recovery_sequencer.sv
// -----------------------------------------------------------------------------
// recovery_sequencer
//
// Purpose:
//   Steers the out-of-order core through branch-mispredict recovery:
//   flush RS/ROB/LSQ, wait for all three flush acknowledgements (bounded by
//   a timeout), restore the rename map, then redirect fetch to the correct PC.
//   A mispredict from an older branch arriving mid-recovery restarts the
//   sequence on the older branch; younger ones are ignored.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   mispredict_valid   mispredict reported this cycle
//   mispredict_pc      correct target PC of the mispredicted branch
//   mispredict_tag     ROB tag of the mispredicted branch
//   rob_head_tag       current ROB head, reference point for tag age
//   rs/rob/lsq_flush_ack  single-cycle flush-done pulses
//   redirect_ready     fetch accepts the redirect
//   flush_req          one-cycle flush command, boundary on flush_tag
//   restore_map        rename-map checkpoint restore enable
//   redirect_valid/pc  fetch redirect, held until redirect_ready
//   stall_front        holds fetch/decode/dispatch while recovering
//   timeout_err        sticky flag: acks did not all arrive in time
//   state              IDLE=0 FLUSH=1 WAIT_ACK=2 RESTORE=3 REDIRECT=4
// -----------------------------------------------------------------------------
module recovery_sequencer #(
  parameter int XLEN           = 32,
  parameter int ROB_TAG_W      = 5,
  parameter int ACK_TIMEOUT    = 15,
  parameter int RESTORE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mispredict_valid,
  input  logic [XLEN-1:0]      mispredict_pc,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  input  logic [ROB_TAG_W-1:0] rob_head_tag,
  input  logic                 rs_flush_ack,
  input  logic                 rob_flush_ack,
  input  logic                 lsq_flush_ack,
  input  logic                 redirect_ready,
  output logic                 flush_req,
  output logic [ROB_TAG_W-1:0] flush_tag,
  output logic                 restore_map,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 stall_front,
  output logic                 timeout_err,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    WAIT_ACK = 3'd2,
    RESTORE  = 3'd3,
    REDIRECT = 3'd4
  } state_e;

  localparam int AckCntW = $clog2(ACK_TIMEOUT + 1);
  localparam int ResCntW = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
  localparam logic [AckCntW-1:0] AckLast = AckCntW'(ACK_TIMEOUT - 1);
  localparam logic [ResCntW-1:0] ResLast = ResCntW'(RESTORE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [XLEN-1:0]      cur_pc_q, cur_pc_d;
  logic [ROB_TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [2:0]           ack_q, ack_d;
  logic [AckCntW-1:0]   ack_cnt_q, ack_cnt_d;
  logic [ResCntW-1:0]   res_cnt_q, res_cnt_d;
  logic                 timeout_q, timeout_d;

  logic                 flush_req_q;
  logic [ROB_TAG_W-1:0] flush_tag_q;
  logic                 restore_map_q;
  logic                 redirect_valid_q;
  logic [XLEN-1:0]      redirect_pc_q;
  logic                 stall_front_q;

  logic [2:0]           ack_in;
  logic [ROB_TAG_W-1:0] new_age;
  logic [ROB_TAG_W-1:0] cur_age;
  logic                 preempt;

  assign ack_in = {rs_flush_ack, rob_flush_ack, lsq_flush_ack};

  // Ages are distances from the ROB head; modular subtraction handles wrap.
  assign new_age = mispredict_tag - rob_head_tag;
  assign cur_age = cur_tag_q - rob_head_tag;
  assign preempt = mispredict_valid && (state_q != IDLE) && (new_age < cur_age);

  // Next-state logic. An older mispredict overrides whatever the current
  // state would have done, including a redirect handshake in the same cycle.
  always_comb begin
    state_d   = state_q;
    cur_pc_d  = cur_pc_q;
    cur_tag_d = cur_tag_q;
    ack_d     = ack_q;
    ack_cnt_d = ack_cnt_q;
    res_cnt_d = res_cnt_q;
    timeout_d = timeout_q;

    case (state_q)
      IDLE: begin
        if (mispredict_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        ack_d   = ack_q | ack_in;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        ack_d = ack_q | ack_in;
        if (&(ack_q | ack_in)) begin
          state_d = RESTORE;
        end else if (ack_cnt_q == AckLast) begin
          timeout_d = 1'b1;
          state_d   = RESTORE;
        end else begin
          ack_cnt_d = ack_cnt_q + AckCntW'(1);
        end
      end
      RESTORE: begin
        if (res_cnt_q == ResLast) begin
          res_cnt_d = '0;
          state_d   = REDIRECT;
        end else begin
          res_cnt_d = res_cnt_q + ResCntW'(1);
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Any entry into FLUSH captures the branch and starts collection afresh.
    if ((state_q == IDLE && mispredict_valid) || preempt) begin
      state_d   = FLUSH;
      cur_pc_d  = mispredict_pc;
      cur_tag_d = mispredict_tag;
      ack_d     = '0;
      ack_cnt_d = '0;
      res_cnt_d = '0;
    end
  end

  // State and bookkeeping registers. Outputs are registered copies decoded
  // from the next state so every output is glitch-free and aligned with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      cur_pc_q         <= '0;
      cur_tag_q        <= '0;
      ack_q            <= '0;
      ack_cnt_q        <= '0;
      res_cnt_q        <= '0;
      timeout_q        <= 1'b0;
      flush_req_q      <= 1'b0;
      flush_tag_q      <= '0;
      restore_map_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_front_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_pc_q         <= cur_pc_d;
      cur_tag_q        <= cur_tag_d;
      ack_q            <= ack_d;
      ack_cnt_q        <= ack_cnt_d;
      res_cnt_q        <= res_cnt_d;
      timeout_q        <= timeout_d;
      flush_req_q      <= (state_d == FLUSH);
      flush_tag_q      <= (state_d == FLUSH) ? cur_tag_d : '0;
      restore_map_q    <= (state_d == RESTORE);
      redirect_valid_q <= (state_d == REDIRECT);
      redirect_pc_q    <= (state_d == REDIRECT) ? cur_pc_d : '0;
      stall_front_q    <= (state_d != IDLE);
    end
  end

  assign flush_req      = flush_req_q;
  assign flush_tag      = flush_tag_q;
  assign restore_map    = restore_map_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign stall_front    = stall_front_q;
  assign timeout_err    = timeout_q;
  assign state          = state_q;

endmodule
